// File: rtl/canvas_write_arbiter_pkg.sv
// Shared definitions for the canvas write arbiter: FSM state encoding and
// the default cursor field widths.
package canvas_write_arbiter_pkg;

  localparam int CANVAS_CX_BITS = 5;
  localparam int CANVAS_CY_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } canvas_state_e;

endpackage

// File: rtl/canvas_write_arbiter.sv
// Canvas write arbiter: turns draw / erase / clear requests into a single
// ready/valid write stream towards the canvas memory. Draw and erase write
// the cell under the cursor; clear sweeps every cell to blank in ascending
// address order. All outputs are registered.
//
// Optional feature: define CANVAS_DEDUP_EN to drop draw/erase requests that
// would repeat the last completed write (same address and data).
module canvas_write_arbiter
  import canvas_write_arbiter_pkg::*;
#(
  parameter int CX_BITS = CANVAS_CX_BITS,
  parameter int CY_BITS = CANVAS_CY_BITS
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       draw_req,
  input  logic                       erase_req,
  input  logic                       clear_req,
  input  logic [CX_BITS-1:0]         cursor_x,
  input  logic [CY_BITS-1:0]         cursor_y,
  input  logic                       wr_ready,
  output logic                       wr_en,
  output logic [CX_BITS+CY_BITS-1:0] wr_addr,
  output logic                       wr_data,
  output logic                       busy,
  output logic                       clear_done
);

  localparam int AW = CX_BITS + CY_BITS;

  canvas_state_e state_q, state_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // Cursor request as it would be written this cycle.
  logic [AW-1:0] req_addr;
  logic          req_data;
  logic          req_dup;

  assign req_addr = {cursor_y, cursor_x};
  assign req_data = ~erase_req;

`ifdef CANVAS_DEDUP_EN
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic          last_data_q, last_data_d;
  logic          last_valid_q, last_valid_d;

  assign req_dup = last_valid_q && (last_addr_q == req_addr) && (last_data_q == req_data);
`else
  assign req_dup = 1'b0;
`endif

  // Next-state and registered-output computation for the three-state FSM.
  always_comb begin
    state_d = state_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef CANVAS_DEDUP_EN
    last_addr_d  = last_addr_q;
    last_data_d  = last_data_q;
    last_valid_d = last_valid_q;
`endif

    unique case (state_q)
      IDLE: begin
        wr_en_d = 1'b0;
        if (clear_req) begin
          state_d = CLEAR;
          wr_en_d = 1'b1;
          cnt_d   = '0;
          addr_d  = '0;
          data_d  = 1'b0;
        end else if ((draw_req || erase_req) && !req_dup) begin
          state_d = WRITE;
          wr_en_d = 1'b1;
          addr_d  = req_addr;
          data_d  = req_data;
        end
      end

      WRITE: begin
        // Address/data stay put until the memory takes them.
        if (wr_ready) begin
          state_d = IDLE;
          wr_en_d = 1'b0;
`ifdef CANVAS_DEDUP_EN
          last_addr_d  = addr_q;
          last_data_d  = data_q;
          last_valid_d = 1'b1;
`endif
        end
      end

      CLEAR: begin
        // Counter only moves on an accepted write and stops at the top
        // address instead of wrapping.
        if (wr_ready) begin
          if (cnt_q == '1) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
`ifdef CANVAS_DEDUP_EN
            last_valid_d = 1'b0;
`endif
          end else begin
            cnt_d  = cnt_q + AW'(1);
            addr_d = cnt_q + AW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CANVAS_DEDUP_EN
  // Record of the last completed draw/erase write.
  always_ff @(posedge clk) begin
    if (clr) begin
      last_addr_q  <= '0;
      last_data_q  <= 1'b0;
      last_valid_q <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_canvas_write_arbiter.sv
// Testbench for canvas_write_arbiter: directed scenarios with literal
// expectations plus a transaction-level reference model compared every cycle.
module tb_canvas_write_arbiter;

  localparam int NCELL = 1024;

`ifdef CANVAS_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       draw_req = 1'b0;
  logic       erase_req = 1'b0;
  logic       clear_req = 1'b0;
  logic [4:0] cursor_x = '0;
  logic [4:0] cursor_y = '0;
  logic       wr_ready = 1'b0;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic       wr_data;
  logic       busy;
  logic       clear_done;

  canvas_write_arbiter #(.CX_BITS(5), .CY_BITS(5)) dut (
    .clk        (clk),
    .clr        (clr),
    .draw_req   (draw_req),
    .erase_req  (erase_req),
    .clear_req  (clear_req),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .wr_ready   (wr_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending single write, or a sweep in progress.
  bit m_write, m_sweep, m_wr_en, m_data, m_busy, m_done;
  int m_addr;
  bit m_lv, m_ld;
  int m_la;

  always @(posedge clk) begin : model
    bit n_write, n_sweep, n_en, n_data, n_done, n_lv, n_ld, d;
    int n_addr, n_la, a;
    n_write = m_write; n_sweep = m_sweep; n_en = m_wr_en; n_data = m_data;
    n_addr = m_addr; n_done = 1'b0; n_lv = m_lv; n_ld = m_ld; n_la = m_la;
    if (clr) begin
      n_write = 0; n_sweep = 0; n_en = 0; n_data = 0; n_addr = 0; n_lv = 0;
    end else if (m_sweep) begin
      if (wr_ready) begin
        if (m_addr == NCELL - 1) begin
          n_sweep = 0; n_en = 0; n_done = 1; n_lv = 0;
        end else begin
          n_addr = m_addr + 1;
        end
      end
    end else if (m_write) begin
      if (wr_ready) begin
        n_write = 0; n_en = 0; n_lv = 1; n_la = m_addr; n_ld = m_data;
      end
    end else begin
      n_en = 0;
      if (clear_req) begin
        n_sweep = 1; n_en = 1; n_addr = 0; n_data = 0;
      end else if (draw_req || erase_req) begin
        a = {22'd0, cursor_y, cursor_x};
        d = !erase_req;
        if (!(DEDUP && m_lv && a == m_la && d == m_ld)) begin
          n_write = 1; n_en = 1; n_addr = a; n_data = d;
        end
      end
    end
    m_write <= n_write; m_sweep <= n_sweep; m_wr_en <= n_en; m_data <= n_data;
    m_addr <= n_addr; m_done <= n_done; m_busy <= n_write | n_sweep;
    m_lv <= n_lv; m_ld <= n_ld; m_la <= n_la;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("wr_en", wr_en, m_wr_en);
      chk("busy", busy, m_busy);
      chk("clear_done", clear_done, m_done);
      if (m_wr_en) begin
        chk("wr_addr", wr_addr, m_addr);
        chk("wr_data", wr_data, m_data);
      end
      if (wr_en && wr_ready) n_acc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until clear_done shows, optionally toggling wr_ready randomly.
  task automatic wait_done(input bit rnd, input int budget, input string name, output int cycles);
    cycles = 0;
    while (clear_done !== 1'b1 && cycles < budget) begin
      if (rnd) wr_ready = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    chk(name, clear_done, 1);
  endtask

  int cyc, acc0, cnt;

  initial begin
    // Reset
    clr = 1'b1;
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear_done", clear_done, 0);
    clr = 1'b0;
    tick();

    // Single draw at (3,2) with memory always ready
    wr_ready = 1; cursor_x = 3; cursor_y = 2; draw_req = 1;
    tick();
    chk("draw_wr_en", wr_en, 1);
    chk("draw_addr", wr_addr, 10'h043);
    chk("draw_data", wr_data, 1);
    chk("draw_busy", busy, 1);
    draw_req = 0;
    tick();
    chk("draw_done_wr_en", wr_en, 0);
    chk("draw_done_busy", busy, 0);

    // Draw+erase together at (31,31), stalled for 4 cycles
    wr_ready = 0; cursor_x = 31; cursor_y = 31; draw_req = 1; erase_req = 1;
    tick();
    draw_req = 0; erase_req = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_wr_en", wr_en, 1);
      chk("stall_addr", wr_addr, 10'h3FF);
      chk("stall_data", wr_data, 0);
      if (i == 4) wr_ready = 1;
      tick();
    end
    chk("stall_after_wr_en", wr_en, 0);

    // clear_req during a stalled draw: draw finishes first, then sweep from 0
    wr_ready = 0; cursor_x = 1; cursor_y = 1; draw_req = 1;
    tick();
    draw_req = 0; clear_req = 1;
    tick(); tick();
    chk("hold_wr_en", wr_en, 1);
    chk("hold_addr", wr_addr, 10'h021);
    chk("hold_data", wr_data, 1);
    wr_ready = 1;
    tick();
    chk("hold_done_wr_en", wr_en, 0);
    tick();
    clear_req = 0;
    chk("sweep_start_wr_en", wr_en, 1);
    chk("sweep_start_addr", wr_addr, 0);
    chk("sweep_start_busy", busy, 1);
    wait_done(1, 6000, "sweep_rnd_done", cyc);
    wr_ready = 1;
    tick();
    chk("sweep_rnd_pulse_end", clear_done, 0);
    chk("sweep_rnd_busy", busy, 0);

    // Full sweep with memory always ready
    clear_req = 1;
    tick();
    clear_req = 0;
    chk("sweep_first_addr", wr_addr, 0);
    acc0 = n_acc;
    wait_done(0, 1100, "sweep_done", cyc);
    chk("sweep_cycles", cyc, 1024);
    chk("sweep_writes", n_acc - acc0, 1024);
    tick();
    chk("sweep_pulse_end", clear_done, 0);
    chk("sweep_busy", busy, 0);

    // clr in the middle of a sweep, then a fresh sweep restarts at 0
    clear_req = 1;
    tick();
    clear_req = 0;
    cyc = 0;
    while (wr_addr !== 10'd500 && cyc < 600) begin
      tick();
      cyc++;
    end
    chk("abort_reach_500", wr_addr, 500);
    clr = 1;
    tick();
    clr = 0;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_addr", wr_addr, 0);
    chk("abort_busy", busy, 0);
    clear_req = 1;
    tick();
    clear_req = 0;
    chk("restart_wr_en", wr_en, 1);
    chk("restart_addr", wr_addr, 0);
    wait_done(0, 1100, "restart_done", cyc);
    tick();

    // clr wins over a simultaneous draw
    clr = 1; draw_req = 1; cursor_x = 4; cursor_y = 4;
    tick();
    chk("clr_prio_wr_en", wr_en, 0);
    chk("clr_prio_busy", busy, 0);
    clr = 0; draw_req = 0;
    tick();

    // Held draw re-issues every IDLE visit with the cursor re-sampled
    wr_ready = 1; cursor_y = 0; draw_req = 1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cursor_x = 5'(i);
      tick();
      if (wr_en) cnt++;
    end
    chk("held_draw_writes", cnt, 6);
    draw_req = 0;
    tick(); tick();

`ifdef CANVAS_DEDUP_EN
    // Repeated identical draw is written once; a new cell is written again
    cursor_x = 5; cursor_y = 5; draw_req = 1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (wr_en) cnt++;
    end
    chk("dedup_writes", cnt, 1);
    cursor_x = 6;
    tick();
    chk("dedup_new_wr_en", wr_en, 1);
    chk("dedup_new_addr", wr_addr, 10'h0A6);
    draw_req = 0;
    tick(); tick();
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      clr       = ($urandom_range(0, 299) == 0);
      draw_req  = 1'($urandom_range(0, 1));
      erase_req = ($urandom_range(0, 3) == 0);
      clear_req = ($urandom_range(0, 499) == 0);
      cursor_x  = 5'($urandom_range(0, 31));
      cursor_y  = 5'($urandom_range(0, 31));
      wr_ready  = 1'($urandom_range(0, 1));
      tick();
    end
    clr = 1; draw_req = 0; erase_req = 0; clear_req = 0;
    tick();
    clr = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
